// File: rtl/ula_pkg.sv
// Shared ULA datapath constants: operand/product widths and MAC defaults.
package ula_pkg;
   localparam int ULA_OP_W      = 8;
   localparam int ULA_PROD_W    = 16;
   localparam int MAC_ACC_W_DEF = 20;
   localparam int MAC_CNT_W_DEF = 8;
endpackage

// File: rtl/multiplicador_8bits.sv
// Combinational 8x8 unsigned multiplier, full 16-bit product.
module multiplicador_8bits (
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [15:0] P
);
   assign P = 16'(A) * 16'(B);
endmodule

// File: rtl/somador_saturado.sv
// Combinational ACC_W-bit + 16-bit unsigned add; clamps to all ones and flags overflow.
module somador_saturado
   import ula_pkg::*;
#(
   parameter int ACC_W = MAC_ACC_W_DEF
) (
   input  logic [ACC_W-1:0]      acc_i,
   input  logic [ULA_PROD_W-1:0] add_i,
   output logic [ACC_W-1:0]      sum_o,
   output logic                  ovf_o
);
   logic [ACC_W:0] wide_sum;

   assign wide_sum = {1'b0, acc_i} + (ACC_W + 1)'(add_i);
   assign ovf_o    = wide_sum[ACC_W];
   assign sum_o    = ovf_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
endmodule

// File: rtl/mac_pipeline_8bits.sv
// Two-stage MAC: operand register -> product/accumulator register; 1 cycle accept-to-output, 1 op/cycle.
// Backpressure: out_ready low with both stages full drops in_ready and freezes all state.
module mac_pipeline_8bits
   import ula_pkg::*;
#(
   parameter int ACC_W = MAC_ACC_W_DEF,
   parameter int CNT_W = MAC_CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ULA_OP_W-1:0]   A,
   input  logic [ULA_OP_W-1:0]   B,
   input  logic                  acumular,
   input  logic                  limpar,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ULA_PROD_W-1:0] P,
   output logic [ACC_W-1:0]      ACC,
   output logic                  saturado,
   output logic [CNT_W-1:0]      contagem
);
   logic                  s1_valid_q, s1_valid_d;
   logic [ULA_OP_W-1:0]   a_q, a_d, b_q, b_d;
   logic                  acum_q, acum_d;
   logic                  out_valid_q, out_valid_d;
   logic [ULA_PROD_W-1:0] p_q, p_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic                  sat_q, sat_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [ULA_PROD_W-1:0] prod;
   logic [ACC_W-1:0]      sat_sum;
   logic                  sum_ovf;
   logic                  adv, accept;

   multiplicador_8bits u_mult (
      .A (a_q),
      .B (b_q),
      .P (prod)
   );

   somador_saturado #(.ACC_W(ACC_W)) u_add (
      .acc_i (acc_q),
      .add_i (prod),
      .sum_o (sat_sum),
      .ovf_o (sum_ovf)
   );

   assign adv      = s1_valid_q && (!out_valid_q || out_ready);
   assign in_ready = !s1_valid_q || adv;
   assign accept   = in_valid && in_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      acum_d      = acum_q;
      out_valid_d = out_valid_q;
      p_d         = p_q;
      acc_d       = acc_q;
      sat_d       = sat_q;
      cnt_d       = cnt_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         a_d        = A;
         b_d        = B;
         acum_d     = acumular;
      end else if (adv) begin
         s1_valid_d = 1'b0;
      end

      if (adv) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // limpar coinciding with an advancing op clears first, so the op always loads
      if (adv) begin
         p_d   = prod;
         cnt_d = limpar ? CNT_W'(1) : cnt_q + CNT_W'(1);
         if (limpar || !acum_q) begin
            acc_d = ACC_W'(prod);
            sat_d = 1'b0;
         end else begin
            acc_d = sat_sum;
            sat_d = sat_q | sum_ovf;
         end
      end else if (limpar) begin
         acc_d = '0;
         sat_d = 1'b0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         acum_q      <= 1'b0;
         out_valid_q <= 1'b0;
         p_q         <= '0;
         acc_q       <= '0;
         sat_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acum_q      <= acum_d;
         out_valid_q <= out_valid_d;
         p_q         <= p_d;
         acc_q       <= acc_d;
         sat_q       <= sat_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign P         = p_q;
   assign ACC       = acc_q;
   assign saturado  = sat_q;
   assign contagem  = cnt_q;
endmodule

// File: tb/tb_mac_pipeline_8bits.sv
// Directed-vector bench for mac_pipeline_8bits with hand-computed expectations.
module tb_mac_pipeline_8bits;
   localparam int ACC_W = 20;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       A;
   logic [7:0]       B;
   logic             acumular;
   logic             limpar;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      P;
   logic [ACC_W-1:0] ACC;
   logic             saturado;
   logic [CNT_W-1:0] contagem;

   int n_checks;
   int n_fail;

   mac_pipeline_8bits #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .acumular  (acumular),
      .limpar    (limpar),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .P         (P),
      .ACC       (ACC),
      .saturado  (saturado),
      .contagem  (contagem)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      A         = '0;
      B         = '0;
      acumular  = 1'b0;
      limpar    = 1'b0;
      out_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_acc", 32'(ACC), 0);
      chk("rst_p", 32'(P), 0);
      chk("rst_cnt", 32'(contagem), 0);
      chk("rst_sat", 32'(saturado), 0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);

      // single load, one-cycle latency
      A = 8'd255; B = 8'd255; acumular = 1'b0; in_valid = 1'b1;
      #1;
      chk("load_in_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("load_lat_not_yet", 32'(out_valid), 0);
      tick();
      chk("load_out_valid", 32'(out_valid), 1);
      chk("load_p", 32'(P), 65025);
      chk("load_acc", 32'(ACC), 65025);
      chk("load_cnt", 32'(contagem), 1);

      // saturation: load then 16 accumulates, back to back
      for (int i = 0; i < 17; i++) begin
         A = 8'd255; B = 8'd255; acumular = (i != 0); in_valid = 1'b1;
         tick();
      end
      chk("sat16_acc", 32'(ACC), 1040400);
      chk("sat16_flag", 32'(saturado), 0);
      chk("sat16_cnt", 32'(contagem), 17);
      A = 8'd1; B = 8'd1; acumular = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("sat17_acc", 32'(ACC), 1048575);
      chk("sat17_flag", 32'(saturado), 1);
      chk("sat17_p", 32'(P), 65025);
      tick();
      chk("sat18_acc", 32'(ACC), 1);
      chk("sat18_flag", 32'(saturado), 0);
      chk("sat18_p", 32'(P), 1);
      chk("sat18_cnt", 32'(contagem), 19);

      // clear without advance while draining the output
      limpar = 1'b1;
      tick();
      limpar = 1'b0;
      chk("clr_acc", 32'(ACC), 0);
      chk("clr_cnt", 32'(contagem), 0);
      chk("clr_out_valid", 32'(out_valid), 0);

      // backpressure: 3*4, 5*6, 7*8 accumulate with out_ready low
      out_ready = 1'b0;
      A = 8'd3; B = 8'd4; acumular = 1'b1; in_valid = 1'b1;
      tick();
      A = 8'd5; B = 8'd6;
      #1;
      chk("bp_ready_2nd", 32'(in_ready), 1);
      tick();
      A = 8'd7; B = 8'd8;
      #1;
      chk("bp_ready_full", 32'(in_ready), 0);
      chk("bp_p_first", 32'(P), 12);
      chk("bp_acc_first", 32'(ACC), 12);
      tick();
      chk("bp_hold_p", 32'(P), 12);
      chk("bp_hold_acc", 32'(ACC), 12);
      chk("bp_hold_ready", 32'(in_ready), 0);
      chk("bp_hold_cnt", 32'(contagem), 1);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("bp_p_2nd", 32'(P), 30);
      chk("bp_acc_2nd", 32'(ACC), 42);
      tick();
      chk("bp_p_3rd", 32'(P), 56);
      chk("bp_acc_3rd", 32'(ACC), 98);
      chk("bp_cnt", 32'(contagem), 3);
      tick();
      chk("bp_drained", 32'(out_valid), 0);
      chk("bp_p_kept", 32'(P), 56);

      // limpar coinciding with advance of 10*10 accumulate
      A = 8'd20; B = 8'd25; acumular = 1'b0; in_valid = 1'b1;
      tick();
      A = 8'd10; B = 8'd10; acumular = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lim_pre_acc", 32'(ACC), 500);
      limpar = 1'b1;
      tick();
      limpar = 1'b0;
      chk("lim_acc", 32'(ACC), 100);
      chk("lim_cnt", 32'(contagem), 1);
      chk("lim_sat", 32'(saturado), 0);
      chk("lim_p", 32'(P), 100);

      // limpar while output is held leaves the pipeline alone
      out_ready = 1'b0;
      limpar = 1'b1;
      tick();
      limpar = 1'b0;
      chk("limh_acc", 32'(ACC), 0);
      chk("limh_cnt", 32'(contagem), 0);
      chk("limh_out_valid", 32'(out_valid), 1);
      chk("limh_p", 32'(P), 100);

      // counter wrap: 256 ops of 0*0
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         A = 8'd0; B = 8'd0; acumular = 1'b1; in_valid = 1'b1;
         tick();
      end
      chk("wrap_cnt_255", 32'(contagem), 255);
      chk("wrap_valid_mid", 32'(out_valid), 1);
      in_valid = 1'b0;
      tick();
      chk("wrap_cnt_0", 32'(contagem), 0);
      chk("wrap_acc", 32'(ACC), 0);
      chk("wrap_valid_last", 32'(out_valid), 1);
      tick();
      chk("wrap_valid_drop", 32'(out_valid), 0);

      // reset mid-stream with both stages occupied
      out_ready = 1'b0;
      A = 8'd3; B = 8'd3; acumular = 1'b0; in_valid = 1'b1;
      tick();
      A = 8'd2; B = 8'd2;
      tick();
      in_valid = 1'b0;
      chk("mrst_pre_acc", 32'(ACC), 9);
      rst = 1'b1;
      #1;
      chk("mrst_async_valid", 32'(out_valid), 0);
      chk("mrst_async_acc", 32'(ACC), 0);
      repeat (3) tick();
      rst = 1'b0;
      #1;
      chk("mrst_in_ready", 32'(in_ready), 1);
      chk("mrst_out_valid", 32'(out_valid), 0);
      chk("mrst_cnt", 32'(contagem), 0);
      chk("mrst_p", 32'(P), 0);
      out_ready = 1'b1;
      tick();
      chk("mrst_no_ghost", 32'(out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
